// File: rtl/reflet_subword_access_pkg.sv
// reflet_subword_access_pkg: size encodings, FSM states and access byte-count helper
package reflet_subword_access_pkg;
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_32 = 2'b01;
  localparam logic [1:0] SIZE_16 = 2'b10;
  localparam logic [1:0] SIZE_8 = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_WR_LO = 3'd2;
  localparam logic [2:0] S_RD_HI = 3'd3;
  localparam logic [2:0] S_WR_HI = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  function automatic logic [5:0] access_n(input logic [1:0] size, input int wordsize);
    int b;
    int n;
    b = wordsize / 8;
    n = size == SIZE_32 ? 4 : size == SIZE_16 ? 2 : size == SIZE_8 ? 1 : b;
    return 6'(n > b ? b : n);
  endfunction
endpackage

// File: rtl/reflet_byte_lane_merge.sv
// reflet_byte_lane_merge: byte insert/extract over a two-word little-endian window
module reflet_byte_lane_merge #(
  parameter int WORDSIZE = 16
) (
  input  logic [WORDSIZE-1:0] lo_word,
  input  logic [WORDSIZE-1:0] hi_word,
  input  logic [WORDSIZE-1:0] new_data,
  input  logic [5:0]          offset,
  input  logic [5:0]          count,
  output logic [WORDSIZE-1:0] merged_lo,
  output logic [WORDSIZE-1:0] merged_hi,
  output logic [WORDSIZE-1:0] extracted
);
  localparam int W2 = 2 * WORDSIZE;
  logic [W2-1:0] mask, lane_mask, lane_data, window, merged, shifted;
  // count never exceeds the word's byte count, so the shift stays inside the double window
  always_comb begin
    mask = (W2'(1) << {count, 3'b000}) - W2'(1);
    lane_mask = mask << {offset, 3'b000};
    lane_data = ({{WORDSIZE{1'b0}}, new_data} & mask) << {offset, 3'b000};
    window = {hi_word, lo_word};
    merged = (window & ~lane_mask) | lane_data;
    shifted = (window >> {offset, 3'b000}) & mask;
  end
  assign merged_lo = merged[WORDSIZE-1:0];
  assign merged_hi = merged[W2-1:WORDSIZE];
  assign extracted = shifted[WORDSIZE-1:0];
endmodule

// File: rtl/reflet_subword_access.sv
// reflet_subword_access: load/store sequencer with read-modify-write and split unaligned accesses
module reflet_subword_access
  import reflet_subword_access_pkg::*;
#(
  parameter int WORDSIZE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic [WORDSIZE-1:0] req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic [5:0]          access_bytes,
  output logic                ram_en,
  output logic                ram_write,
  output logic [WORDSIZE-1:0] ram_addr,
  output logic [WORDSIZE-1:0] ram_wdata,
  input  logic [WORDSIZE-1:0] ram_rdata,
  input  logic                ram_ack
);
  localparam int B = WORDSIZE / 8;
  logic [2:0] state, next_state;
  logic lat_write, span, req_full, hi_phase;
  logic [5:0] lat_n, offset, req_offset;
  logic [WORDSIZE-1:0] lat_addr, lat_wdata, lo_word, hi_word, lo_addr, merged_lo, merged_hi, extracted;
  assign access_bytes = access_n(req_size, WORDSIZE);
  assign req_offset = 6'(req_addr & WORDSIZE'(B - 1));
  assign offset = 6'(lat_addr & WORDSIZE'(B - 1));
  assign lo_addr = lat_addr & ~WORDSIZE'(B - 1);
  assign span = 7'(offset) + 7'(lat_n) > 7'(B);
  // aligned full-word stores overwrite every lane, so no read is needed
  assign req_full = req_write && access_bytes == 6'(B) && req_offset == 6'd0;
  assign req_ready = state == S_IDLE && !reset;
  assign ram_en = state != S_IDLE && state != S_DONE;
  assign ram_write = state == S_WR_LO || state == S_WR_HI;
  assign hi_phase = state == S_RD_HI || state == S_WR_HI;
  assign ram_addr = !ram_en ? '0 : hi_phase ? lo_addr + WORDSIZE'(B) : lo_addr;
  assign ram_wdata = state == S_WR_LO ? merged_lo : state == S_WR_HI ? merged_hi : '0;
  assign resp_valid = state == S_DONE;
  assign resp_rdata = resp_valid && !lat_write ? extracted : '0;
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = req_valid ? (req_full ? S_WR_LO : S_RD_LO) : S_IDLE;
      S_RD_LO: next_state = !ram_ack ? state : lat_write ? S_WR_LO : span ? S_RD_HI : S_DONE;
      S_WR_LO: next_state = !ram_ack ? state : span ? S_RD_HI : S_DONE;
      S_RD_HI: next_state = !ram_ack ? state : lat_write ? S_WR_HI : S_DONE;
      S_WR_HI: next_state = !ram_ack ? state : S_DONE;
      default: next_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      lat_write <= 1'b0;
      lat_n <= '0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lo_word <= '0;
      hi_word <= '0;
    end else begin
      state <= next_state;
      if (req_valid && state == S_IDLE) begin
        lat_write <= req_write;
        lat_n <= access_bytes;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state == S_RD_LO && ram_ack) lo_word <= ram_rdata;
      if (state == S_RD_HI && ram_ack) hi_word <= ram_rdata;
    end
  end
  reflet_byte_lane_merge #(.WORDSIZE(WORDSIZE)) merge (
    .lo_word(lo_word),
    .hi_word(hi_word),
    .new_data(lat_wdata),
    .offset(offset),
    .count(lat_n),
    .merged_lo(merged_lo),
    .merged_hi(merged_hi),
    .extracted(extracted)
  );
endmodule
